// File: rtl/ps2_scan_decoder_pkg.sv
// ps2_pkg: shared definitions for the PS/2 Set-2 scan decoder.
//   - byte constants for prefixes (E0/F0/E1), keyboard status bytes and the
//     two shift make codes
//   - decoder state enum
//   - layout of an event word as stored in the event FIFO
//   - ASCII lookup helper (only when PS2_ASCII_MAP_EN is defined)
// Optional feature macro: PS2_ASCII_MAP_EN (adds an 8-bit ASCII field to every
// event; without it an event word is 10 bits wide).
package ps2_pkg;

  localparam logic [7:0] CODE_E0      = 8'hE0;
  localparam logic [7:0] CODE_F0      = 8'hF0;
  localparam logic [7:0] CODE_E1      = 8'hE1;
  localparam logic [7:0] CODE_FA      = 8'hFA;
  localparam logic [7:0] CODE_AA      = 8'hAA;
  localparam logic [7:0] CODE_EE      = 8'hEE;
  localparam logic [7:0] CODE_FE      = 8'hFE;
  localparam logic [7:0] CODE_00      = 8'h00;
  localparam logic [7:0] CODE_FF      = 8'hFF;
  localparam logic [7:0] CODE_LSHIFT  = 8'h12;
  localparam logic [7:0] CODE_RSHIFT  = 8'h59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  // Event word layout: {[ascii,] extended, released, code}
  localparam int EV_CODE_LSB = 0;
  localparam int EV_CODE_W   = 8;
  localparam int EV_REL_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;
`ifdef PS2_ASCII_MAP_EN
  localparam int EV_ASCII_LSB = 10;
  localparam int EV_W         = 18;
`else
  localparam int EV_W         = 10;
`endif

  // Bytes the keyboard sends about itself rather than about a key.
  function automatic logic is_status(input logic [7:0] b);
    return (b == CODE_FA) || (b == CODE_AA) || (b == CODE_EE) ||
           (b == CODE_FE) || (b == CODE_00) || (b == CODE_FF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == CODE_E0) || (b == CODE_F0) || (b == CODE_E1);
  endfunction

`ifdef PS2_ASCII_MAP_EN
  // Letters honour shift; digits and the few control keys ignore it.
  function automatic logic [7:0] ascii_lookup(input logic [7:0] code,
                                              input logic       shift);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
      8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
      8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
      8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
      8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
      8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
      8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      return shift ? (ch - 8'h20) : ch;
    end
    case (code)
      8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
      8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
      8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
      8'h46: ch = 8'h39;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction
`endif

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if: byte-in / event-out bundle of the scan decoder.
//   code_in, code_valid : raw scan byte and its one-cycle strobe
//   ev_valid, ev_ready  : event handshake toward the application
//   ev_code, ev_released, ev_extended, ev_ascii : head event fields
//   status_ack, kbd_error, overflow : keyboard status and error flags
// modport slave  : the decoder side
// modport master : the receiver/application side
// Optional feature macro: PS2_ASCII_MAP_EN (ev_ascii is always present).
interface ps2_scan_decoder_if;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_released;
  logic       ev_extended;
  logic [7:0] ev_ascii;
  logic       status_ack;
  logic       kbd_error;
  logic       overflow;

  modport slave (
    input  code_in, code_valid, ev_ready,
    output ev_valid, ev_code, ev_released, ev_extended, ev_ascii,
           status_ack, kbd_error, overflow
  );

  modport master (
    output code_in, code_valid, ev_ready,
    input  ev_valid, ev_code, ev_released, ev_extended, ev_ascii,
           status_ack, kbd_error, overflow
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: small synchronous FIFO holding decoded key events.
//   clk, rst   : clock, asynchronous active-high reset
//   push, push_data, full : write side (push while full without pop is ignored)
//   pop, empty, head      : read side; head is the stored word at the read
//                           pointer and stays put until popped
// A push and a pop in the same cycle always both take effect when the FIFO is
// full; when empty only the push happens.
// Optional feature macro: none (width comes from the WIDTH parameter).
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // When full, a simultaneous pop frees the slot being written (wr == rd),
  // and the consumer has already seen the old head this cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: folds a raw Set-2 scan byte stream into key events.
//   clock_fpga : system clock (rising edge)
//   reset      : asynchronous active-high reset
//   bus        : ps2_scan_decoder_if.slave
//                in : code_in/code_valid (receiver bytes), ev_ready
//                out: ev_valid + head event fields, status_ack (pulse on FA),
//                     kbd_error (sticky), overflow (sticky, event dropped)
// Prefixes E0/F0 are merged into the following code; E1 starts the Pause
// sequence whose remaining PAUSE_SKIP bytes are swallowed.
// Optional feature macro: PS2_ASCII_MAP_EN (shift tracking + ASCII per event;
// otherwise ev_ascii is tied to 8'h00).
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_SKIP = 7
) (
  input  logic              clock_fpga,
  input  logic              reset,
  ps2_scan_decoder_if.slave bus
);

  localparam int SKIP_W = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;

  state_t            state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              push, push_ext, push_rel;
  logic [EV_W-1:0]   push_data;
  logic [EV_W-1:0]   head;
  logic              fifo_full, fifo_empty, pop;

  assign pop = bus.ev_valid && bus.ev_ready;

  // Decoder: prefix bookkeeping and event generation, one byte per strobe.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    push     = 1'b0;
    push_ext = 1'b0;
    push_rel = 1'b0;
    if (bus.code_valid) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (bus.code_in == CODE_E0) begin
            state_d = ST_EXT;
          end else if (bus.code_in == CODE_F0) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if ((bus.code_in == CODE_E1) && (state_q == ST_IDLE)) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_W'(PAUSE_SKIP);
          end else if (is_status(bus.code_in)) begin
            ack_d   = (bus.code_in == CODE_FA);
            err_d   = err_q || (bus.code_in == CODE_FE) ||
                      (bus.code_in == CODE_00) || (bus.code_in == CODE_FF);
            state_d = ST_IDLE;
          end else begin
            push     = 1'b1;
            push_ext = (state_q == ST_EXT);
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          // A prefix or status byte where a key code belongs aborts the break.
          if (is_status(bus.code_in) || is_prefix(bus.code_in)) begin
            err_d = err_q || (bus.code_in == CODE_00) || (bus.code_in == CODE_FF);
          end else begin
            push     = 1'b1;
            push_rel = 1'b1;
            push_ext = (state_q == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          if (skip_q <= SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ovf_d = ovf_q || (push && fifo_full && !pop);
  end

`ifdef PS2_ASCII_MAP_EN
  logic shift_l_q, shift_l_d, shift_r_q, shift_r_d;

  // Shift keys still become events; they also steer the letter case.
  // The ASCII of an event uses the shift state from before that event.
  always_comb begin
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    if (push && !push_ext && (bus.code_in == CODE_LSHIFT)) shift_l_d = !push_rel;
    if (push && !push_ext && (bus.code_in == CODE_RSHIFT)) shift_r_d = !push_rel;
    push_data = {(push_ext || push_rel) ? 8'h00
                   : ascii_lookup(bus.code_in, shift_l_q || shift_r_q),
                 push_ext, push_rel, bus.code_in};
  end

  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
    end else begin
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
    end
  end

  assign bus.ev_ascii = head[EV_ASCII_LSB +: 8];
`else
  always_comb begin
    push_data = {push_ext, push_rel, bus.code_in};
  end

  assign bus.ev_ascii = 8'h00;
`endif

  // Decoder state, status pulse and sticky flags.
  always_ff @(posedge clock_fpga or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clock_fpga),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign bus.ev_valid    = !fifo_empty;
  assign bus.ev_code     = head[EV_CODE_LSB +: EV_CODE_W];
  assign bus.ev_released = head[EV_REL_BIT];
  assign bus.ev_extended = head[EV_EXT_BIT];
  assign bus.status_ack  = ack_q;
  assign bus.kbd_error   = err_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Sits directly downstream of the ps2 byte receiver and consumes its data_out/new_code stream of raw Set-2 scan bytes. Folds prefix bytes (E0 extended, F0 break, E1 pause) and keyboard status bytes into single key events {extended, released, code}. Buffers the events in a small FIFO with a valid/ready handshake toward the application (LED/display/control logic).

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, >= 2
PAUSE_SKIP, 7, bytes discarded after an E1 prefix (Pause key sequence)

Ports:
clock_fpga  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
code_in  in  8  scan byte from ps2 receiver (its data_out)
code_valid  in  1  one-cycle strobe, code_in valid (receiver new_code)
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head when ev_valid && ev_ready
ev_code  out  8  head event: base scan code
ev_released  out  1  head event: 1 = break (key up), 0 = make
ev_extended  out  1  head event: E0-prefixed key
ev_ascii  out  8  head event: ASCII (see Optional Feature)
status_ack  out  1  1-cycle pulse on FA
kbd_error  out  1  sticky: 00/FF received, or FE/AA-fail path (see below)
overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset (async, active-high): state IDLE, FIFO empty, skip counter 0; ev_valid=0, ev_code=0, ev_released=0, ev_extended=0, ev_ascii=0, status_ack=0, kbd_error=0, overflow=0. Reset mid-sequence discards any pending prefix.
- Bytes are processed only on cycles with code_valid=1; code_in ignored otherwise.
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0,F0 seen), SKIP (pause bytes).
- IDLE: E0->EXT; F0->BRK; E1->SKIP, counter=PAUSE_SKIP; FA->pulse status_ack, stay; AA/EE->stay, no event; FE/00/FF->set kbd_error, stay; other->push {ext=0,rel=0,code}.
- EXT: F0->EXT_BRK; E0 repeat->stay EXT; status bytes handled as in IDLE and state returns to IDLE; other->push {1,0,code}, ->IDLE.
- BRK: push {0,1,code}, ->IDLE (status/prefix bytes here: no push, ->IDLE, 00/FF set kbd_error).
- EXT_BRK: push {1,1,code}, ->IDLE (same status rule as BRK).
- SKIP: each byte decrements counter; at 1->0 transition return IDLE; no events. Pause key yields no event.
- Latency: event written to FIFO on the clock edge sampling code_valid; ev_valid high from the next cycle when FIFO was empty.
- FIFO: pop on ev_valid && ev_ready; head outputs registered/stable while ev_valid && !ev_ready. Push+pop same cycle always succeeds, including full and empty (empty: push only; head appears next cycle). Push when full with no pop: event dropped, overflow set, FIFO contents unchanged. Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Sticky flags clear only on reset.

Optional Feature:
Macro PS2_ASCII_MAP_EN.
- Defined: decoder tracks shift state (make/break of 12 and 59, non-extended; shift keys still produce events); each pushed event carries ev_ascii from a Set-2 table: letters (lower/upper by shift), digits 0-9, space 29->20, enter 5A->0D, backspace 66->08; unmapped, break, or extended events -> 00. ASCII stored in FIFO with the event.
- Undefined: no shift tracking or table; ev_ascii constant 8'h00, FIFO entries 10 bits.

Decomposition:
- Package ps2_pkg: byte constants (E0, F0, E1, FA, AA, EE, FE, 00, FF, shift codes 12/59), state enum, event field widths/offsets, ASCII table function (under macro).
- Sub-module ps2_event_fifo (parameter DEPTH, WIDTH; push/full/pop/empty, registered head); decoder FSM stays in ps2_scan_decoder.

Test Plan:
- Byte 75 -> one event {ext=0,rel=0,code=75}, ev_valid 1 cycle after strobe; then F0,75 -> {0,1,75}.
- E0,75 then E0,F0,75 -> {1,0,75} then {1,1,75}; no events for prefixes.
- E1,14,77,E1,F0,14,F0,77 then 1C -> only {0,0,1C}; FA -> status_ack 1 cycle; 00 -> kbd_error=1 sticky.
- ev_ready=0, send 5 make codes 15,1D,24,2D,2C with FIFO_DEPTH=4 -> first four held in order, 2C dropped, overflow=1; push+pop on full cycle -> no loss.
- Reset asserted after F0 -> next 75 gives {0,0,75}; all outputs 0 during reset.
- PS2_ASCII_MAP_EN: 1C -> ev_ascii 61; 12,1C -> 41; F0,12,1C -> 61; undefined -> 00.
